// File: rtl/alu_exec_stage_pkg.sv
// ALU configuration codes shared by ALU control decode and the execute stage,
// plus a decode helper that maps raw codes onto an internal operation enum.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [4:0] CONF_AND = 5'b00000;
   localparam logic [4:0] CONF_OR  = 5'b00001;
   localparam logic [4:0] CONF_ADD = 5'b00010;
   localparam logic [4:0] CONF_SUB = 5'b00110;
   localparam logic [4:0] CONF_SLT = 5'b00111;
   localparam logic [4:0] CONF_NOR = 5'b01000;
   localparam logic [4:0] CONF_XOR = 5'b01001;
   localparam logic [4:0] CONF_SLL = 5'b01010;
   localparam logic [4:0] CONF_SRL = 5'b10000;
   localparam logic [4:0] CONF_SRA = 5'b10001;

   typedef enum logic [3:0] {
      OP_AND,
      OP_OR,
      OP_ADD,
      OP_SUB,
      OP_SLT,
      OP_NOR,
      OP_XOR,
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_ILLEGAL
   } alu_op_e;

   function automatic alu_op_e decode_conf(input logic [4:0] conf);
      alu_op_e op;
      case (conf)
         CONF_AND: op = OP_AND;
         CONF_OR:  op = OP_OR;
         CONF_ADD: op = OP_ADD;
         CONF_SUB: op = OP_SUB;
         CONF_SLT: op = OP_SLT;
         CONF_NOR: op = OP_NOR;
         CONF_XOR: op = OP_XOR;
         CONF_SLL: op = OP_SLL;
         CONF_SRL: op = OP_SRL;
         CONF_SRA: op = OP_SRA;
         default:  op = OP_ILLEGAL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU: result, signed-overflow flag and illegal-code flag from
// the ALU configuration code, sign mode and the two operands.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [4:0]       conf,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             illegal
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [4:0]       shamt;
   logic             lt;
   logic             add_ovf;
   logic             sub_ovf;

   assign sum   = a + b;
   assign diff  = a - b;
   assign shamt = a[4:0];
   assign lt    = sign ? ($signed(a) < $signed(b)) : (a < b);

   // Overflow is only meaningful when the operands are treated as signed.
   assign add_ovf = sign & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1]  != a[WIDTH-1]);
   assign sub_ovf = sign & (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      result  = '0;
      ovf     = 1'b0;
      illegal = 1'b0;
      case (decode_conf(conf))
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_ADD: begin
            result = sum;
            ovf    = add_ovf;
         end
         OP_SUB: begin
            result = diff;
            ovf    = sub_ovf;
         end
         OP_SLT: result = {{(WIDTH-1){1'b0}}, lt};
         OP_NOR: result = ~(a | b);
         OP_XOR: result = a ^ b;
         OP_SLL: result = b << shamt;
         OP_SRL: result = b >> shamt;
         OP_SRA: result = $signed(b) >>> shamt;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: alu_core followed by a one-entry result register with
// valid/ready handshake, flush, and saturating retired-op / overflow counters.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_conf,
   input  logic             in_sign,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_illegal,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] ovf_count
);

   logic [WIDTH-1:0] core_result;
   logic             core_ovf;
   logic             core_illegal;
   logic             accept;
   logic             retire;
   logic [CNT_W-1:0] cnt_one;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .conf    (in_conf),
      .sign    (in_sign),
      .a       (in_a),
      .b       (in_b),
      .result  (core_result),
      .ovf     (core_ovf),
      .illegal (core_illegal)
   );

   // Handshake: a transfer happens on a rising edge where valid & ready are
   // both high; in_ready depends only on flush, out_valid and out_ready, so a
   // held result that is retiring frees the slot for an accept on that edge.
   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign retire   = out_valid && out_ready && !flush;
   assign cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_ovf     <= 1'b0;
         out_illegal <= 1'b0;
         op_count    <= '0;
         ovf_count   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else begin
         if (retire) begin
            if (op_count != {CNT_W{1'b1}})
               op_count <= op_count + cnt_one;
            if (out_ovf && (ovf_count != {CNT_W{1'b1}}))
               ovf_count <= ovf_count + cnt_one;
         end
         if (accept) begin
            out_valid   <= 1'b1;
            out_result  <= core_result;
            out_zero    <= (core_result == '0);
            out_ovf     <= core_ovf;
            out_illegal <= core_illegal;
         end else if (retire) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
